// File: rtl/nios_system_control_seq.sv
// Avalon-MM pulse-train sequencer: programmable high/low time and pulse count on a 1-bit control line.
// Optional CONTROL_SEQ_IRQ_EN macro implements the IRQ_EN bit and the level interrupt.
module nios_system_control_seq #(
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        out_port,
   output logic        irq
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] high_ticks, low_ticks, count_reg;
   logic [CNT_W-1:0] phase_cnt, phase_nxt;
   logic [CNT_W-1:0] pulse_cnt, pulse_nxt;
   logic             invert, invert_nxt;
   logic             irq_en;
   logic             done, done_set, done_nxt;
   logic             out_nxt;
   logic             busy;

   logic wr_en, ctrl_wr, start, stop, done_clr;
   logic unused_wdata;

   // A zero-tick phase would vanish; it is stretched to one cycle instead.
   function automatic logic [CNT_W-1:0] ticks_floor(input logic [CNT_W-1:0] t);
      return (t == '0) ? ONE : t;
   endfunction

   assign wr_en    = chipselect & ~write_n;
   assign ctrl_wr  = wr_en & (address == 2'd0);
   assign stop     = ctrl_wr & writedata[1];
   assign start    = ctrl_wr & writedata[0] & ~writedata[1];
   assign done_clr = ctrl_wr & writedata[4];
   assign busy     = (state != ST_IDLE);

   assign unused_wdata = ^writedata;

   always_comb begin
      state_nxt = state;
      phase_nxt = phase_cnt;
      pulse_nxt = pulse_cnt;
      done_set  = 1'b0;
      if (stop) begin
         state_nxt = ST_IDLE;
      end else if (start) begin
         state_nxt = ST_HIGH;
         phase_nxt = ticks_floor(high_ticks);
         pulse_nxt = count_reg;
      end else begin
         case (state)
            ST_HIGH: begin
               if (phase_cnt <= ONE) begin
                  state_nxt = ST_LOW;
                  phase_nxt = ticks_floor(low_ticks);
               end else begin
                  phase_nxt = phase_cnt - ONE;
               end
            end
            ST_LOW: begin
               if (phase_cnt > ONE) begin
                  phase_nxt = phase_cnt - ONE;
               end else if (pulse_cnt == ONE) begin
                  state_nxt = ST_IDLE;
                  done_set  = 1'b1;
               end else begin
                  // A loaded pulse count of zero never decrements: continuous mode.
                  state_nxt = ST_HIGH;
                  phase_nxt = ticks_floor(high_ticks);
                  if (pulse_cnt != '0) pulse_nxt = pulse_cnt - ONE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign invert_nxt = ctrl_wr ? writedata[2] : invert;
   assign done_nxt   = done_set | (done & ~done_clr);
   assign out_nxt    = (state_nxt == ST_HIGH) ? ~invert_nxt : invert_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         phase_cnt  <= '0;
         pulse_cnt  <= '0;
         high_ticks <= ONE;
         low_ticks  <= ONE;
         count_reg  <= ONE;
         invert     <= 1'b0;
         done       <= 1'b0;
         out_port   <= 1'b0;
      end else begin
         state     <= state_nxt;
         phase_cnt <= phase_nxt;
         pulse_cnt <= pulse_nxt;
         invert    <= invert_nxt;
         done      <= done_nxt;
         out_port  <= out_nxt;
         if (wr_en && address == 2'd1) high_ticks <= writedata[CNT_W-1:0];
         if (wr_en && address == 2'd2) low_ticks  <= writedata[CNT_W-1:0];
         if (wr_en && address == 2'd3) count_reg  <= writedata[CNT_W-1:0];
      end
   end

`ifdef CONTROL_SEQ_IRQ_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en <= writedata[3];
         irq <= done & irq_en;
      end
   end
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata = {27'd0, out_port, irq_en, invert, done, busy};
         2'd1: readdata = 32'(high_ticks);
         2'd2: readdata = 32'(low_ticks);
         2'd3: readdata = 32'(count_reg);
         default: readdata = '0;
      endcase
   end

endmodule
